// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and master indices for the Wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN,
        ARB_DRAIN
    } wb_arb_state_t;

    localparam int unsigned WB_MST_ICACHE = 0;
    localparam int unsigned WB_MST_DCACHE = 1;
    localparam int unsigned WB_MST_DM     = 2;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping modulo NumReq.
module wb_rr_arbiter_rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 3,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [IdxW-1:0]   grant_o,
    output logic              any_o
);

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = last_i;
        any_o   = 1'b0;
        // Scan from the far end so the nearest requester after last_i overrides the rest.
        for (int i = int'(NumReq); i >= 1; i--) begin
            idx = (int'(last_i) + i) % int'(NumReq);
            if (req_i[idx]) begin
                grant_o = IdxW'(idx);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone port between NUM_MASTERS bus masters.
// Grants per cyc frame, bounds outstanding strobes, preempts starving frames, aborts hung ones.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 32,
    parameter int unsigned ACK_TIMEOUT     = 1023,
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_MASTERS*64-1:0] i_m_wb_adr,
    input  logic [NUM_MASTERS*64-1:0] i_m_wb_dat,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_we,
    input  logic [NUM_MASTERS*8-1:0]  i_m_wb_sel,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_lock,
    output logic [63:0]               o_m_wb_dat,
    output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
    output logic [NUM_MASTERS-1:0]    o_m_wb_stall,
    output logic [NUM_MASTERS-1:0]    o_m_wb_rty,
    output logic [63:0]               o_wb_adr,
    output logic [63:0]               o_wb_dat,
    output logic                      o_wb_we,
    output logic [7:0]                o_wb_sel,
    output logic                      o_wb_stb,
    output logic                      o_wb_cyc,
    input  logic [63:0]               i_wb_dat,
    input  logic                      i_wb_ack,
    input  logic                      i_wb_stall,
    output logic [IW-1:0]             o_owner,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE_LIMIT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    wb_arb_state_t          state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          last_q, last_d;
    logic [OW-1:0]          outst_q, outst_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   own_cyc, own_stb, own_lock;
    logic                   busy, others_req, starve_hit, drain_done, timeout, block;
    logic                   accept, ack_dec, retry;

    wb_rr_arbiter_rr_pick #(
        .NumReq (NUM_MASTERS),
        .IdxW   (IW)
    ) u_pick (
        .req_i   (i_m_wb_cyc),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        owner_oh = '0;
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_lock = 1'b0;
        o_wb_adr = '0;
        o_wb_dat = '0;
        o_wb_we  = 1'b0;
        o_wb_sel = '0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            if (owner_q == IW'(k)) begin
                owner_oh[k] = 1'b1;
                own_cyc     = i_m_wb_cyc[k];
                own_stb     = i_m_wb_stb[k];
                own_lock    = i_m_wb_lock[k];
                o_wb_adr    = i_m_wb_adr[64*k +: 64];
                o_wb_dat    = i_m_wb_dat[64*k +: 64];
                o_wb_we     = i_m_wb_we[k];
                o_wb_sel    = i_m_wb_sel[8*k +: 8];
            end
        end
    end

    assign busy       = (state_q != ARB_IDLE);
    assign others_req = |(i_m_wb_cyc & ~owner_oh);
    assign starve_hit = (state_q == ARB_OWN) && others_req && !own_lock && (wait_q == WAIT_LAST);
    assign drain_done = (state_q == ARB_DRAIN) && own_cyc && (outst_q == '0);
    assign timeout    = busy && (outst_q != '0) && !i_wb_ack && (timer_q == TIMER_LAST);
    // Starvation blocks the owner already in the cycle the limit is reached.
    assign block      = (outst_q == OUT_MAX) || (state_q == ARB_DRAIN) || starve_hit || timeout;
    assign o_wb_cyc   = busy && own_cyc && !drain_done;
    assign o_wb_stb   = o_wb_cyc && own_stb && !block;
    assign accept     = o_wb_stb && !i_wb_stall;
    assign ack_dec    = busy && i_wb_ack && (outst_q != '0);
    assign retry      = drain_done || timeout;

    always_comb begin
        o_m_wb_stall = '1;
        o_m_wb_ack   = '0;
        o_m_wb_rty   = '0;
        if (busy) begin
            o_m_wb_stall = ~owner_oh | {NUM_MASTERS{i_wb_stall | block}};
            o_m_wb_ack   = owner_oh & {NUM_MASTERS{i_wb_ack}};
            o_m_wb_rty   = owner_oh & {NUM_MASTERS{retry}};
        end
    end

    assign o_m_wb_dat = i_wb_dat;
    assign o_owner    = owner_q;
    assign o_busy     = busy;
    assign o_timeout  = timeout;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        outst_d = outst_q;
        wait_d  = wait_q;
        timer_d = timer_q;
        unique case (state_q)
            ARB_IDLE: begin
                outst_d = '0;
                wait_d  = '0;
                timer_d = '0;
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN, ARB_DRAIN: begin
                outst_d = outst_q + OW'(accept) - OW'(ack_dec);
                timer_d = (i_wb_ack || outst_q == '0) ? '0 : timer_q + TW'(1);
                if (state_q == ARB_OWN) begin
                    wait_d = (others_req && !own_lock) ? wait_q + WW'(1) : '0;
                    if (starve_hit) begin
                        state_d = ARB_DRAIN;
                        wait_d  = '0;
                    end
                end
                if (timeout || !own_cyc || drain_done) begin
                    state_d = ARB_IDLE;
                    last_d  = owner_q;
                    outst_d = '0;
                    wait_d  = '0;
                    timer_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            outst_q <= '0;
            wait_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            wait_q  <= wait_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter: grant order, outstanding limit, starvation,
// lock, ack timeout and mid-frame reset.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    localparam int unsigned N = 3;
    localparam logic [63:0] ADR0 = 64'h1000_0000_0000_0010;
    localparam logic [63:0] ADR1 = 64'h2000_0000_0000_0020;
    localparam logic [63:0] ADR2 = 64'h3000_0000_0000_0030;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [N*64-1:0] m_adr, m_dat;
    logic [N-1:0]    m_we, m_stb, m_cyc, m_lock;
    logic [N*8-1:0]  m_sel;
    logic [63:0]     o_m_wb_dat;
    logic [N-1:0]    o_m_wb_ack, o_m_wb_stall, o_m_wb_rty;
    logic [63:0]     o_wb_adr, o_wb_dat;
    logic            o_wb_we, o_wb_stb, o_wb_cyc;
    logic [7:0]      o_wb_sel;
    logic [63:0]     i_wb_dat;
    logic            i_wb_ack = 1'b0;
    logic            i_wb_stall;
    logic [1:0]      o_owner;
    logic            o_busy, o_timeout;

    int n_cmp, n_bad;
    int sent, acks1, acks_oth, stalls, first_stall, rty_cnt, tmo_cnt;
    bit seen_rty;

    always #5 i_clk = ~i_clk;

    wb_rr_arbiter dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_m_wb_adr   (m_adr),
        .i_m_wb_dat   (m_dat),
        .i_m_wb_we    (m_we),
        .i_m_wb_sel   (m_sel),
        .i_m_wb_stb   (m_stb),
        .i_m_wb_cyc   (m_cyc),
        .i_m_wb_lock  (m_lock),
        .o_m_wb_dat   (o_m_wb_dat),
        .o_m_wb_ack   (o_m_wb_ack),
        .o_m_wb_stall (o_m_wb_stall),
        .o_m_wb_rty   (o_m_wb_rty),
        .o_wb_adr     (o_wb_adr),
        .o_wb_dat     (o_wb_dat),
        .o_wb_we      (o_wb_we),
        .o_wb_sel     (o_wb_sel),
        .o_wb_stb     (o_wb_stb),
        .o_wb_cyc     (o_wb_cyc),
        .i_wb_dat     (i_wb_dat),
        .i_wb_ack     (i_wb_ack),
        .i_wb_stall   (i_wb_stall),
        .o_owner      (o_owner),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    // Slave: acks each accepted strobe four cycles later (three quiet cycles in between).
    logic       slave_en = 1'b0;
    logic       acc_s = 1'b0;
    logic [3:0] pipe = '0;
    always @(negedge i_clk) acc_s = o_wb_stb & ~i_wb_stall;
    always @(posedge i_clk) begin
        #1;
        pipe = {pipe[2:0], acc_s & slave_en};
        i_wb_ack = pipe[3];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_adr = {ADR2, ADR1, ADR0};
        m_dat = {64'hD2, 64'hD1, 64'hD0};
        m_sel = 24'hFF_0F_F0;
        m_we = '0;
        m_stb = '0;
        m_cyc = '0;
        m_lock = '0;
        i_wb_dat = 64'hCAFE;
        i_wb_stall = 1'b0;
        i_reset = 1'b1;

        // Reset state
        tick(); tick(); mid();
        check("rst_busy", o_busy, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_stall", o_m_wb_stall, 3'b111);
        check("rst_ack", o_m_wb_ack, 0);
        check("rst_rty", o_m_wb_rty, 0);
        check("rst_tmo", o_timeout, 0);
        check("rst_owner", o_owner, 0);

        // Simultaneous request from icache and debug: icache first, then debug
        tick(); i_reset = 1'b0; m_cyc[WB_MST_ICACHE] = 1'b1; m_cyc[WB_MST_DM] = 1'b1; mid();
        check("t1_lat_cyc", o_wb_cyc, 0);
        tick(); mid();
        check("t1_owner0", o_owner, WB_MST_ICACHE);
        check("t1_busy", o_busy, 1);
        check("t1_cyc", o_wb_cyc, 1);
        check("t1_adr0", o_wb_adr, ADR0);
        check("t1_stall", o_m_wb_stall, 3'b110);
        check("t1_rdat", o_m_wb_dat, 64'hCAFE);
        tick(); m_cyc[WB_MST_ICACHE] = 1'b0; mid();
        check("t1_drop_cyc", o_wb_cyc, 0);
        tick(); mid();
        check("t1_gap_busy", o_busy, 0);
        check("t1_gap_cyc", o_wb_cyc, 0);
        tick(); mid();
        check("t1_owner2", o_owner, WB_MST_DM);
        check("t1_adr2", o_wb_adr, ADR2);
        check("t1_sel2", o_wb_sel, 8'hFF);
        tick(); m_cyc = '0; tick();

        // dcache burst of 6 strobes against 4-deep outstanding limit
        slave_en = 1'b1;
        tick(); m_cyc[WB_MST_DCACHE] = 1'b1; m_stb[WB_MST_DCACHE] = 1'b1;
        sent = 0; acks1 = 0; acks_oth = 0; stalls = 0; first_stall = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            m_stb[WB_MST_DCACHE] = (sent < 6);
            mid();
            if (i == 1) check("t2_owner", o_owner, WB_MST_DCACHE);
            if (i == 5) check("t2_stb_blocked", o_wb_stb, 0);
            if (m_stb[WB_MST_DCACHE]) begin
                if (o_m_wb_stall[WB_MST_DCACHE]) begin
                    stalls++;
                    if (first_stall == 0) first_stall = i;
                end else begin
                    sent++;
                end
            end
            acks1 += int'(o_m_wb_ack[WB_MST_DCACHE]);
            acks_oth += int'(o_m_wb_ack[WB_MST_ICACHE]) + int'(o_m_wb_ack[WB_MST_DM]);
        end
        check("t2_sent", sent, 6);
        check("t2_acks", acks1, 6);
        check("t2_acks_other", acks_oth, 0);
        check("t2_stall_cycles", stalls, 1);
        check("t2_first_stall", first_stall, 5);
        tick(); m_cyc = '0; m_stb = '0; tick();

        // Unlocked icache frame starves dcache: preempt via drain and rty
        tick(); m_cyc[WB_MST_ICACHE] = 1'b1;
        rty_cnt = 0; seen_rty = 1'b0;
        for (int r = 1; r <= 40; r++) begin
            tick();
            m_cyc[WB_MST_DCACHE] = (r >= 2);
            m_cyc[WB_MST_ICACHE] = !seen_rty;
            m_stb[WB_MST_ICACHE] = !seen_rty && (r == 31 || r >= 33);
            mid();
            if (o_m_wb_rty != '0) begin
                rty_cnt++;
                seen_rty = 1'b1;
            end
            if (r == 31) check("t3_accept", o_wb_stb, 1);
            if (r == 32) check("t3_no_block", o_m_wb_stall[WB_MST_ICACHE], 0);
            if (r == 33) check("t3_block_stall", o_m_wb_stall[WB_MST_ICACHE], 1);
            if (r == 33) check("t3_block_stb", o_wb_stb, 0);
            if (r == 35) check("t3_drain_ack", o_m_wb_ack, 3'b001);
            if (r == 35) check("t3_drain_rty", o_m_wb_rty, 0);
            if (r == 35) check("t3_drain_cyc", o_wb_cyc, 1);
            if (r == 36) check("t3_rty", o_m_wb_rty, 3'b001);
            if (r == 36) check("t3_rty_cyc", o_wb_cyc, 0);
            if (r == 37) check("t3_idle", o_busy, 0);
            if (r == 38) check("t3_owner1", o_owner, WB_MST_DCACHE);
            if (r == 38) check("t3_busy1", o_busy, 1);
        end
        check("t3_rty_count", rty_cnt, 1);
        tick(); m_cyc = '0; m_stb = '0; tick();

        // Same with lock: icache keeps the bus until it drops cyc
        tick(); m_cyc[WB_MST_ICACHE] = 1'b1; m_lock[WB_MST_ICACHE] = 1'b1;
        rty_cnt = 0;
        for (int r = 1; r <= 44; r++) begin
            tick();
            m_cyc[WB_MST_DCACHE] = (r >= 2);
            if (r >= 42) begin
                m_cyc[WB_MST_ICACHE] = 1'b0;
                m_lock[WB_MST_ICACHE] = 1'b0;
            end
            mid();
            if (o_m_wb_rty != '0) rty_cnt++;
            if (r == 33) check("t4_no_block", o_m_wb_stall[WB_MST_ICACHE], 0);
            if (r == 41) check("t4_owner0", o_owner, WB_MST_ICACHE);
            if (r == 41) check("t4_cyc", o_wb_cyc, 1);
            if (r == 42) check("t4_drop", o_wb_cyc, 0);
            if (r == 43) check("t4_idle", o_busy, 0);
            if (r == 44) check("t4_owner1", o_owner, WB_MST_DCACHE);
        end
        check("t4_rty_count", rty_cnt, 0);
        tick(); m_cyc = '0; tick();

        // Ack timeout: debug module strobe never acked
        slave_en = 1'b0;
        tick(); m_cyc[WB_MST_DM] = 1'b1;
        tmo_cnt = 0;
        for (int t = 1; t <= 1026; t++) begin
            tick();
            m_stb[WB_MST_DM] = (t == 1);
            if (t >= 1025) begin
                m_cyc[WB_MST_DM] = 1'b0;
                m_cyc[WB_MST_ICACHE] = 1'b1;
            end
            mid();
            tmo_cnt += int'(o_timeout);
            if (t == 1) check("t5_accept", o_wb_stb, 1);
            if (t == 1023) check("t5_no_tmo_yet", o_timeout, 0);
            if (t == 1024) check("t5_tmo", o_timeout, 1);
            if (t == 1024) check("t5_rty", o_m_wb_rty, 3'b100);
            if (t == 1024) check("t5_cyc_held", o_wb_cyc, 1);
            if (t == 1025) check("t5_cyc_drop", o_wb_cyc, 0);
            if (t == 1025) check("t5_idle", o_busy, 0);
            if (t == 1026) check("t5_regrant", o_owner, WB_MST_ICACHE);
            if (t == 1026) check("t5_regrant_busy", o_busy, 1);
        end
        check("t5_tmo_count", tmo_cnt, 1);

        // Reset with two strobes in flight
        tick(); m_stb[WB_MST_ICACHE] = 1'b1; mid();
        check("t6_acc1", o_wb_stb, 1);
        tick(); mid();
        check("t6_acc2", o_wb_stb, 1);
        tick(); m_stb = '0; i_reset = 1'b1; m_cyc[WB_MST_DM] = 1'b1; mid();
        tick(); i_reset = 1'b0; mid();
        check("t6_cyc", o_wb_cyc, 0);
        check("t6_busy", o_busy, 0);
        check("t6_stall", o_m_wb_stall, 3'b111);
        check("t6_rty", o_m_wb_rty, 0);
        check("t6_ack", o_m_wb_ack, 0);
        tick(); mid();
        check("t6_owner0", o_owner, WB_MST_ICACHE);
        check("t6_busy1", o_busy, 1);
        for (int s = 1; s <= 5; s++) begin
            tick(); m_stb[WB_MST_ICACHE] = 1'b1; mid();
            if (s == 4) check("t6_outst_cleared", o_m_wb_stall[WB_MST_ICACHE], 0);
            if (s == 5) check("t6_outst_full", o_m_wb_stall[WB_MST_ICACHE], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
